// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared definitions for the LFSR word generator.
//   lfsr_state_e : generator control states
//   TAPS_8/16/32 : default feedback masks (bit i set => state[i] feeds the XOR)
//   lfsr_fb()    : feedback bit for a state/tap-mask pair (up to 64 bits)
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } lfsr_state_e;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'hA3000000;

   function automatic logic lfsr_fb(input logic [63:0] state,
                                    input logic [63:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/lfsr_word_pack.sv
// lfsr_word_pack -- serial-to-parallel collector with a valid/ready holding register.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   clear         : drop the partial (or pending full) collector word; holding register kept
//   shift_en      : shift bit_in into the collector LSB this cycle
//   bit_in        : serial bit; the first bit of a word ends up in out_data[OUT_W-1]
//   out_data      : held word
//   out_valid     : out_data holds an unconsumed word
//   out_ready     : consumer accepts the held word when out_valid is also high
//   coll_full     : a complete word is waiting in the collector for the holding register
//   hold_free     : holding register can take a word this cycle
module lfsr_word_pack #(
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   output logic             coll_full,
   output logic             hold_free
);

   localparam int unsigned CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

   logic [OUT_W-1:0] coll;
   logic [OUT_W-1:0] coll_shift;
   logic [CW-1:0]    cnt;
   logic             wrap;
   logic             load_shift;
   logic             load_pending;

   generate
      if (OUT_W == 1) begin : g_one
         assign coll_shift = bit_in;
      end else begin : g_many
         assign coll_shift = {coll[OUT_W-2:0], bit_in};
      end
   endgenerate

   assign wrap      = (cnt == LAST);
   assign hold_free = !out_valid || out_ready;

   // A word completing while the holding register is busy parks in the
   // collector (coll_full) instead of being lost; it moves across as soon
   // as the holding register frees up.
   assign load_shift   = shift_en && !clear && wrap && hold_free;
   assign load_pending = coll_full && !clear && hold_free;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coll      <= '0;
         cnt       <= '0;
         coll_full <= 1'b0;
      end else if (clear) begin
         coll      <= '0;
         cnt       <= '0;
         coll_full <= 1'b0;
      end else if (shift_en) begin
         coll <= coll_shift;
         cnt  <= wrap ? '0 : cnt + 1'b1;
         if (wrap && !hold_free) begin
            coll_full <= 1'b1;
         end
      end else if (load_pending) begin
         coll      <= '0;
         coll_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (load_shift) begin
         out_data  <= coll_shift;
         out_valid <= 1'b1;
      end else if (load_pending) begin
         out_data  <= coll;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen -- Fibonacci LFSR pseudo-random word generator.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   en          : run enable; the LFSR advances only while running
//   seed_valid  : load seed_data (SEED_DEF if seed_data is zero); wins over advancing
//   seed_data   : seed value, WIDTH bits
//   out_data    : assembled OUT_W-bit word, first emitted bit in the MSB
//   out_valid   : out_data holds an unconsumed word
//   out_ready   : consumer handshake
//   bit_out     : current serial bit, state[WIDTH-1]
// Optional macro LFSR_GEN_PERIOD_CNT_EN adds:
//   period_done : one-cycle pulse when the state returns to the last loaded seed
//   period_len  : advance count latched at that moment
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
   parameter int unsigned      OUT_W    = 8,
   parameter logic [WIDTH-1:0] SEED_DEF = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_valid,
   input  logic [WIDTH-1:0] seed_data,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             bit_out
`ifdef LFSR_GEN_PERIOD_CNT_EN
   ,
   output logic             period_done,
   output logic [WIDTH-1:0] period_len
`endif
);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] adv_state;
   logic [WIDTH-1:0] seed_val;
   logic             fb;
   logic             state_zero;
   logic             advance;
   logic             clear;
   logic             coll_full;
   logic             hold_free;

   lfsr_state_e fsm;
   lfsr_state_e fsm_next;

   assign fb         = lfsr_fb(64'(state), 64'(TAPS));
   assign adv_state  = {state[WIDTH-2:0], fb};
   assign seed_val   = (seed_data == '0) ? SEED_DEF : seed_data;
   assign state_zero = (state == '0);
   assign bit_out    = state[WIDTH-1];

   // Advancing stops while a finished word is parked in the collector, so
   // no bit is ever shifted into a word that cannot yet be handed over.
   assign advance = (fsm == RUN) && !coll_full && !seed_valid && !state_zero;
   assign clear   = seed_valid && !state_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED_DEF;
      end else if (state_zero) begin
         state <= SEED_DEF;
      end else if (seed_valid) begin
         state <= seed_val;
      end else if (advance) begin
         state <= adv_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE: begin
            if (en) fsm_next = RUN;
         end
         RUN: begin
            if (!en)                         fsm_next = IDLE;
            else if (coll_full && !hold_free) fsm_next = STALL;
         end
         STALL: begin
            if (!en)           fsm_next = IDLE;
            else if (hold_free) fsm_next = RUN;
         end
         default: fsm_next = IDLE;
      endcase
   end

   lfsr_word_pack #(
      .OUT_W (OUT_W)
   ) u_pack (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .shift_en  (advance),
      .bit_in    (state[WIDTH-1]),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .coll_full (coll_full),
      .hold_free (hold_free)
   );

`ifdef LFSR_GEN_PERIOD_CNT_EN
   logic [WIDTH-1:0] adv_cnt;
   logic [WIDTH-1:0] last_seed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adv_cnt     <= '0;
         last_seed   <= SEED_DEF;
         period_done <= 1'b0;
         period_len  <= '0;
      end else begin
         period_done <= 1'b0;
         if (state_zero) begin
            adv_cnt   <= '0;
            last_seed <= SEED_DEF;
         end else if (seed_valid) begin
            adv_cnt   <= '0;
            last_seed <= seed_val;
         end else if (advance) begin
            if (adv_state == last_seed) begin
               period_done <= 1'b1;
               period_len  <= adv_cnt + 1'b1;
               adv_cnt     <= '0;
            end else begin
               adv_cnt <= adv_cnt + 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;
   import lfsr_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        seed_valid;
   logic [15:0] seed_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        bit_out;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

`ifdef LFSR_GEN_PERIOD_CNT_EN
   logic        pd16;
   logic [15:0] pl16;
   logic        en4;
   logic [7:0]  od4;
   logic        ov4;
   logic        bo4;
   logic        pd4;
   logic [3:0]  pl4;
`endif

   always #5 clk = ~clk;

   lfsr_gen #(
      .WIDTH    (16),
      .TAPS     (16'hB400),
      .OUT_W    (8),
      .SEED_DEF (16'h0001)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .seed_valid (seed_valid),
      .seed_data  (seed_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bit_out    (bit_out)
`ifdef LFSR_GEN_PERIOD_CNT_EN
      ,
      .period_done (pd16),
      .period_len  (pl16)
`endif
   );

`ifdef LFSR_GEN_PERIOD_CNT_EN
   lfsr_gen #(
      .WIDTH    (4),
      .TAPS     (4'hC),
      .OUT_W    (8),
      .SEED_DEF (4'h1)
   ) dut4 (
      .clk         (clk),
      .rst         (rst),
      .en          (en4),
      .seed_valid  (1'b0),
      .seed_data   (4'h0),
      .out_data    (od4),
      .out_valid   (ov4),
      .out_ready   (1'b1),
      .bit_out     (bo4),
      .period_done (pd4),
      .period_len  (pl4)
   );
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] step16(input logic [15:0] s);
      logic f;
      f = ^(s & 16'hB400);
      return {s[14:0], f};
   endfunction

   task automatic do_reset();
      rst        = 1'b1;
      en         = 1'b0;
      seed_valid = 1'b0;
      seed_data  = 16'h0000;
      out_ready  = 1'b1;
`ifdef LFSR_GEN_PERIOD_CNT_EN
      en4 = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] m;

      // Reset values
      do_reset();
      check("rst_valid", 64'(out_valid), 64'(1'b0));
      check("rst_data",  64'(out_data),  64'(8'h00));
      check("rst_state", 64'(dut.state), 64'(16'h0001));
      check("rst_fsm",   64'(dut.fsm),   64'(IDLE));
      check("rst_bit",   64'(bit_out),   64'(1'b0));

      // Free-running words with out_ready held high
      en = 1'b1;
      tick();
      check("run_fsm", 64'(dut.fsm), 64'(RUN));
      for (int e = 2; e <= 17; e++) begin
         tick();
         if (e == 8)  check("w0_early", 64'(out_valid), 64'(1'b0));
         if (e == 9) begin
            check("w0_valid", 64'(out_valid), 64'(1'b1));
            check("w0_data",  64'(out_data),  64'(8'h00));
         end
         if (e == 16) check("w1_early", 64'(out_valid), 64'(1'b0));
         if (e == 17) begin
            check("w1_valid", 64'(out_valid), 64'(1'b1));
            check("w1_data",  64'(out_data),  64'(8'h01));
         end
      end

      // Back-pressure: held word stable, FSM stalls, state frozen
      do_reset();
      en = 1'b1;
      for (int e = 1; e <= 9; e++) tick();
      check("bp_w0_valid", 64'(out_valid), 64'(1'b1));
      out_ready = 1'b0;
      for (int e = 10; e <= 39; e++) begin
         tick();
         check("bp_hold", 64'({out_valid, out_data}), 64'({1'b1, 8'h00}));
         if (e == 25) check("bp_state_mid", 64'(dut.state), 64'(16'h002D));
      end
      check("bp_fsm",   64'(dut.fsm),   64'(STALL));
      check("bp_state", 64'(dut.state), 64'(16'h002D));
      out_ready = 1'b1;
      tick();
      check("bp_swap_valid", 64'(out_valid), 64'(1'b1));
      check("bp_swap_data",  64'(out_data),  64'(8'h01));
      check("bp_resume_fsm", 64'(dut.fsm),   64'(RUN));
      tick();
      check("bp_drain", 64'(out_valid), 64'(1'b0));

      // Seed handling
      do_reset();
      seed_valid = 1'b1;
      seed_data  = 16'h0000;
      tick();
      seed_valid = 1'b0;
      check("seed_zero", 64'(dut.state), 64'(16'h0001));
      seed_valid = 1'b1;
      seed_data  = 16'hACE1;
      tick();
      seed_valid = 1'b0;
      check("seed_ace1", 64'(dut.state), 64'(16'hACE1));
      check("seed_bit0", 64'(bit_out),   64'(1'b1));
      en = 1'b1;
      tick();
      check("seed_idle_hold", 64'(dut.state), 64'(16'hACE1));
      m = 16'hACE1;
      for (int i = 0; i < 24; i++) begin
         tick();
         m = step16(m);
         check("seed_seq_bit", 64'(bit_out), 64'(m[15]));
      end
      check("seed_seq_state", 64'(dut.state), 64'(m));

      // Seed load while a word is held: holding register untouched
      do_reset();
      en        = 1'b1;
      for (int e = 1; e <= 9; e++) tick();
      out_ready  = 1'b0;
      seed_valid = 1'b1;
      seed_data  = 16'h1234;
      tick();
      seed_valid = 1'b0;
      check("seedhold_valid", 64'(out_valid), 64'(1'b1));
      check("seedhold_data",  64'(out_data),  64'(8'h00));
      check("seedhold_state", 64'(dut.state), 64'(16'h1234));

      // Asynchronous reset three bits into the second word
      do_reset();
      en        = 1'b1;
      out_ready = 1'b0;
      for (int e = 1; e <= 12; e++) tick();
      check("mid_pre_valid", 64'(out_valid), 64'(1'b1));
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'(1'b0));
      check("mid_rst_data",  64'(out_data),  64'(8'h00));
      check("mid_rst_state", 64'(dut.state), 64'(16'h0001));
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         tick();
         if (e == 8) check("re_w0_early", 64'(out_valid), 64'(1'b0));
         if (e == 9) check("re_w0", 64'({out_valid, out_data}), 64'({1'b1, 8'h00}));
         if (e == 17) check("re_w1", 64'({out_valid, out_data}), 64'({1'b1, 8'h01}));
      end

`ifdef LFSR_GEN_PERIOD_CNT_EN
      // Period detection on a 4-bit maximal-length LFSR
      do_reset();
      check("per_rst_done", 64'(pd4), 64'(1'b0));
      check("per_rst_len",  64'(pl4), 64'(4'd0));
      en4 = 1'b1;
      tick();
      for (int e = 2; e <= 17; e++) begin
         tick();
         if (e == 15) check("per_early", 64'(pd4), 64'(1'b0));
         if (e == 16) begin
            check("per_done", 64'(pd4), 64'(1'b1));
            check("per_len",  64'(pl4), 64'(4'd15));
         end
         if (e == 17) check("per_pulse", 64'(pd4), 64'(1'b0));
      end
      check("per_w16_idle", 64'(pd16), 64'(1'b0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, legal range 4..64.
REQ-002 Parameter TAPS, default 16'hB400: feedback tap mask, WIDTH bits wide; bit i set means state[i] feeds the XOR.
REQ-003 Parameter OUT_W, default 8: output word width, legal range 1..32.
REQ-004 Parameter SEED_DEF, default 1: seed loaded at reset and substituted for any all-zero seed.
REQ-005 Port clk, input, 1 bit: clock, rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port en, input, 1 bit: run enable; generation advances only while high.
REQ-008 Port seed_valid, input, 1 bit: load seed_data this cycle.
REQ-009 Port seed_data, input, WIDTH bits: seed value.
REQ-010 Port out_data, output, OUT_W bits: assembled pseudo-random word.
REQ-011 Port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the word when out_valid and out_ready are both high.
REQ-013 Port bit_out, output, 1 bit: current serial bit, equal to state[WIDTH-1].

Function
REQ-014 Advance rule: fb = XOR-reduce(state & TAPS); next state = {state[WIDTH-2:0], fb}; the emitted bit is state[WIDTH-1] before the shift.
REQ-015 FSM states: IDLE, RUN, STALL.
- IDLE -> RUN when en=1.
- RUN -> IDLE when en=0.
- RUN -> STALL when the collector is full and the holding register is occupied.
- STALL -> RUN when the holding register is freed.
- STALL -> IDLE when en=0.
REQ-016 The LFSR advances one step per cycle in RUN only; it never advances in IDLE or STALL.
REQ-017 Collector: each emitted bit shifts in at the LSB, so the first emitted bit of a word ends in out_data[OUT_W-1].
REQ-018 A modulo-OUT_W bit counter tracks collector fill; when it wraps, the word moves to the holding register and out_valid goes high.
REQ-019 First out_valid rises in the cycle after the OUT_W-th advance following entry to RUN.
REQ-020 out_data stays stable while out_valid=1 and out_ready=0.
REQ-021 Transfer and a new word arriving in the same cycle: the new word replaces the old one and out_valid stays high, with no bubble.
REQ-022 seed_valid has priority over advancing.
- State loads seed_data, or SEED_DEF if seed_data is zero.
- Collector and bit counter clear.
- Holding register and out_valid are unaffected.
REQ-023 Lockup guard: if state is ever all-zero, the next cycle loads SEED_DEF regardless of en.

Reset
REQ-024 Reset values:
- state = SEED_DEF
- FSM = IDLE
- collector and bit counter = 0
- out_data = 0, out_valid = 0
REQ-025 Reset asserted mid-word discards the partial word and any held word, with no output glitch beyond the asynchronous clear.

Configuration
REQ-026 Macro LFSR_GEN_PERIOD_CNT_EN.
- Defined: adds output period_done (1 bit) and output period_len (WIDTH bits).
- An advance counter clears on seed load and reset.
- period_done pulses for one cycle when state returns to the last loaded seed.
- period_len latches the count at that moment.
- Undefined: neither port nor the counter exists.

Structure
REQ-027 Package lfsr_pkg holds:
- the FSM state enum
- default tap-mask constants for widths 8, 16, 32
- a function computing the feedback bit
REQ-028 Sub-module lfsr_word_pack contains the collector, bit counter and valid/ready holding register; lfsr_gen contains the LFSR, FSM and seed logic.

Verification
REQ-029 Reset, then en=1 with out_ready=1 (defaults) -> first word 8'h00 at cycle 9, second word 8'h01 at cycle 17.
REQ-030 out_ready=0 for 30 cycles after the first word -> out_valid stays high, out_data is stable at 8'h00, FSM is in STALL, and state freezes after the second word fills.
REQ-031 seed_valid with seed_data=0 -> state = 16'h0001; seed 16'hACE1 -> bit_out follows the reference-model sequence from 16'hACE1.
REQ-032 rst asserted 3 cycles into a word -> out_valid=0 and state=16'h0001 immediately; the next word after restart equals the post-reset first word.
REQ-033 With LFSR_GEN_PERIOD_CNT_EN, WIDTH=4, TAPS=4'hC, seed 1 -> period_done after 15 advances with period_len=15.
